spu_ln_sqrt_pipe: RTL and testbench

Parametrised multi-cycle restoring integer square root for the SPU LayerNorm path. It is the successor to the single-bit-per-cycle sqrt and adds four things: configurable iterations per cycle, fractional result bits, optional round-to-nearest, and a remainder output. It uses a valid/ready handshake on both sides and carries a tag through so the LN controller can match results to requests. It sits between the variance accumulator and the reciprocal/normalise stage.

---
 rtl/spu_ln_sqrt_pipe.sv | 144 ++++++++++++++
 tb/tb_spu_ln_sqrt_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spu_ln_sqrt_pipe.sv
// Multi-cycle restoring square root with STEPS iterations per clock, FRAC fractional bits, optional rounding and remainder.
// Latency C+1 edges from accept to dout_valid_o; a held result blocks new input until it is consumed.
module spu_ln_sqrt_pipe #(
    parameter int DW    = 16,
    parameter int FRAC  = 0,
    parameter int STEPS = 1,
    parameter int TAGW  = 4
) (
    input  logic                              core_clk,
    input  logic                              rst_n,
    input  logic [DW-1:0]                     din_i,
    input  logic [TAGW-1:0]                   din_tag_i,
    input  logic                              round_en_i,
    input  logic                              din_valid_i,
    output logic                              din_ready_o,
    output logic [(DW+(DW%2))/2+FRAC-1:0]     sqrt_o,
    output logic [(DW+(DW%2))/2+FRAC:0]       rem_o,
    output logic [TAGW-1:0]                   tag_o,
    output logic                              dout_valid_o,
    input  logic                              dout_ready_i,
    output logic                              busy_o
);

    localparam int DE = DW + (DW % 2);
    localparam int N  = DE / 2 + FRAC;
    localparam int QW = N;
    localparam int C  = N / STEPS;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int RW = 2 * N;

    if ((N % STEPS) != 0) begin : g_bad_steps
        $error("spu_ln_sqrt_pipe: STEPS must divide N");
    end

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_rad;
    logic [QW-1:0]   r_q;
    logic [QW:0]     r_rem;
    logic [CW-1:0]   r_cnt;
    logic [TAGW-1:0] r_tag;
    logic            r_round;
    logic [QW-1:0]   r_sqrt;
    logic [QW:0]     r_rem_out;
    logic [TAGW-1:0] r_tag_out;

    logic [RW-1:0]   w_rad_nxt;
    logic [QW-1:0]   w_q_nxt;
    logic [QW:0]     w_rem_nxt;
    logic [QW+2:0]   w_t;
    logic [QW+2:0]   w_d;
    logic            w_ge;
    logic            w_round_up;
    logic [QW-1:0]   w_sqrt_fin;
    logic            w_accept;

    // STEPS chained restoring iterations; t/d keep two guard bits so nothing is lost in the compare.
    always_comb begin
        w_rad_nxt = r_rad;
        w_q_nxt   = r_q;
        w_rem_nxt = r_rem;
        w_t       = '0;
        w_d       = '0;
        w_ge      = 1'b0;
        for (int s = 0; s < STEPS; s++) begin
            w_t       = {w_rem_nxt, w_rad_nxt[RW-1 -: 2]};
            w_d       = {1'b0, w_q_nxt, 2'b01};
            w_ge      = (w_t >= w_d);
            w_rem_nxt = w_ge ? (QW+1)'(w_t - w_d) : (QW+1)'(w_t);
            w_q_nxt   = (w_q_nxt << 1) | QW'(w_ge);
            w_rad_nxt = w_rad_nxt << 2;
        end
        w_round_up = r_round && (w_rem_nxt > {1'b0, w_q_nxt}) && !(&w_q_nxt);
        w_sqrt_fin = w_q_nxt + QW'(w_round_up);
    end

    always_comb begin
        w_state_nxt  = r_state;
        din_ready_o  = 1'b0;
        dout_valid_o = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                din_ready_o = 1'b1;
                if (din_valid_i) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                dout_valid_o = 1'b1;
                din_ready_o  = dout_ready_i;
                if (dout_ready_i) w_state_nxt = din_valid_i ? S_CALC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = din_valid_i && din_ready_o;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rad     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_round   <= 1'b0;
            r_sqrt    <= '0;
            r_rem_out <= '0;
            r_tag_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rad   <= RW'(din_i) << (2 * FRAC);
                r_q     <= '0;
                r_rem   <= '0;
                r_tag   <= din_tag_i;
                r_round <= round_en_i;
                r_cnt   <= CW'(C - 1);
            end else if (r_state == S_CALC) begin
                r_rad <= w_rad_nxt;
                r_q   <= w_q_nxt;
                r_rem <= w_rem_nxt;
                if (r_cnt == '0) begin
                    r_sqrt    <= w_sqrt_fin;
                    r_rem_out <= w_rem_nxt;
                    r_tag_out <= r_tag;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign sqrt_o = r_sqrt;
    assign rem_o  = r_rem_out;
    assign tag_o  = r_tag_out;

endmodule

// File: tb/tb_spu_ln_sqrt_pipe.sv
// Randomised bench for spu_ln_sqrt_pipe across five parameter sets, checked against an arithmetic sqrt model.
module tb_spu_ln_sqrt_pipe;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, obs, exp);
        end
    endtask

    // floor(sqrt(v)) by bisection; v stays below 2^32 here
    function automatic longint isqrt(input longint v);
        longint lo = 0;
        longint hi = 65536;
        while (hi - lo > 1) begin
            longint mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    typedef struct {
        int     cfg;
        longint din;
        bit     rnd;
        longint sq;
        longint rem;
    } dir_t;

    dir_t dirs [9] = '{
        '{0, 400,   1'b0, 20,  0},
        '{0, 65535, 1'b1, 255, 510},
        '{0, 0,     1'b0, 0,   0},
        '{1, 2,     1'b0, 22,  28},
        '{1, 2,     1'b1, 23,  28},
        '{2, 400,   1'b1, 20,  0},
        '{3, 65535, 1'b0, 255, 510},
        '{4, 32767, 1'b0, 181, 6},
        '{4, 32767, 1'b1, 181, 6}
    };

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int P_DW    = (g == 4) ? 15 : 16;
        localparam int P_FRAC  = (g == 1) ? 4 : 0;
        localparam int P_STEPS = (g == 2) ? 2 : ((g == 3) ? 4 : 1);
        localparam int P_N     = (P_DW + (P_DW % 2)) / 2 + P_FRAC;
        localparam int P_C     = P_N / P_STEPS;

        logic              rst_n;
        logic [P_DW-1:0]   din;
        logic [3:0]        tag_i;
        logic              rnd;
        logic              vld;
        logic              rdy;
        logic [P_N-1:0]    sq;
        logic [P_N:0]      rem;
        logic [3:0]        tag_o;
        logic              dvld;
        logic              drdy;
        logic              busy;

        spu_ln_sqrt_pipe #(.DW(P_DW), .FRAC(P_FRAC), .STEPS(P_STEPS), .TAGW(4)) u_dut (
            .core_clk     (core_clk),
            .rst_n        (rst_n),
            .din_i        (din),
            .din_tag_i    (tag_i),
            .round_en_i   (rnd),
            .din_valid_i  (vld),
            .din_ready_o  (rdy),
            .sqrt_o       (sq),
            .rem_o        (rem),
            .tag_o        (tag_o),
            .dout_valid_o (dvld),
            .dout_ready_i (drdy),
            .busy_o       (busy)
        );

        function automatic longint m_rem(input longint d);
            longint v = d << (2 * P_FRAC);
            longint q = isqrt(v);
            return v - q * q;
        endfunction

        // nearest: sqrt(v) > q + 1/2  <=>  4v > (2q+1)^2; the all-ones root cannot grow
        function automatic longint m_sq(input longint d, input bit r);
            longint v = d << (2 * P_FRAC);
            longint q = isqrt(v);
            if (r && (4 * v > (2 * q + 1) * (2 * q + 1)) && (q != (64'd1 << P_N) - 1)) return q + 1;
            return q;
        endfunction

        function automatic string nm(input string s);
            return $sformatf("c%0d_%s", g, s);
        endfunction

        task automatic accept(input longint d, input int t, input bit r);
            chk(nm("rdy_before_accept"), rdy, 1);
            din   = P_DW'(d);
            tag_i = t[3:0];
            rnd   = r;
            vld   = 1'b1;
            @(posedge core_clk); #1;
            vld   = 1'b0;
        endtask

        // entered #1 after the accept edge; edges counts that edge too
        task automatic wait_valid(output int edges);
            edges = 1;
            while (!dvld && edges < 200) begin
                @(posedge core_clk); #1;
                edges++;
            end
            if (!dvld) chk(nm("valid_timeout"), 0, 1);
        endtask

        task automatic check_result(input int edges, input longint esq, input longint erem, input int t);
            chk(nm("latency"), edges, P_C + 1);
            chk(nm("sqrt"), sq, esq);
            chk(nm("rem"), rem, erem);
            chk(nm("tag"), tag_o, t);
        endtask

        task automatic consume();
            drdy = 1'b1;
            @(posedge core_clk); #1;
            drdy = 1'b0;
            chk(nm("vld_after_consume"), dvld, 0);
            chk(nm("rdy_after_consume"), rdy, 1);
        endtask

        task automatic txn(input longint d, input int t, input bit r, input longint esq, input longint erem);
            int e;
            accept(d, t, r);
            wait_valid(e);
            check_result(e, esq, erem, t);
            consume();
        endtask

        function automatic longint rand_din();
            if ($urandom_range(0, 7) == 0) return (64'd1 << P_DW) - 1;
            return longint'($urandom_range(0, (1 << P_DW) - 1));
        endfunction

        initial begin
            int e;
            longint d1, d2;
            int t1, t2;
            bit r1, r2;
            rst_n = 1'b0; din = '0; tag_i = '0; rnd = 1'b0; vld = 1'b0; drdy = 1'b0;
            repeat (3) @(posedge core_clk);
            #1;
            chk(nm("rst_sqrt"), sq, 0);
            chk(nm("rst_rem"), rem, 0);
            chk(nm("rst_tag"), tag_o, 0);
            chk(nm("rst_vld"), dvld, 0);
            chk(nm("rst_busy"), busy, 0);
            @(negedge core_clk) rst_n = 1'b1;
            @(posedge core_clk); #1;

            foreach (dirs[i]) begin
                if (dirs[i].cfg == g)
                    txn(dirs[i].din, (i * 3 + 1) % 16, dirs[i].rnd, dirs[i].sq, dirs[i].rem);
            end

            for (int i = 0; i < 25; i++) begin
                d1 = rand_din();
                r1 = 1'($urandom_range(0, 1));
                t1 = int'($urandom_range(0, 15));
                txn(d1, t1, r1, m_sq(d1, r1), m_rem(d1));
            end

            // held result under backpressure, then consume and accept on one edge
            d1 = rand_din(); d2 = rand_din();
            r1 = 1'($urandom_range(0, 1)); r2 = 1'($urandom_range(0, 1));
            t1 = int'($urandom_range(0, 15)); t2 = t1 ^ 5;
            accept(d1, t1, r1);
            wait_valid(e);
            check_result(e, m_sq(d1, r1), m_rem(d1), t1);
            repeat (10) begin
                @(posedge core_clk); #1;
                chk(nm("stall_vld"), dvld, 1);
                chk(nm("stall_rdy"), rdy, 0);
                chk(nm("stall_sqrt"), sq, m_sq(d1, r1));
                chk(nm("stall_rem"), rem, m_rem(d1));
                chk(nm("stall_tag"), tag_o, t1);
            end
            din = P_DW'(d2); tag_i = t2[3:0]; rnd = r2; vld = 1'b1; drdy = 1'b1;
            #1;
            chk(nm("b2b_rdy"), rdy, 1);
            @(posedge core_clk); #1;
            vld = 1'b0; drdy = 1'b0;
            chk(nm("b2b_vld"), dvld, 0);
            chk(nm("b2b_busy"), busy, 1);
            wait_valid(e);
            check_result(e, m_sq(d2, r2), m_rem(d2), t2);
            consume();

            // reset during CALC discards the operation
            accept(rand_din(), 7, 1'b0);
            @(posedge core_clk); #1;
            chk(nm("busy_before_rst"), busy, 1);
            rst_n = 1'b0;
            #1;
            chk(nm("midrst_sqrt"), sq, 0);
            chk(nm("midrst_rem"), rem, 0);
            chk(nm("midrst_tag"), tag_o, 0);
            chk(nm("midrst_vld"), dvld, 0);
            chk(nm("midrst_busy"), busy, 0);
            @(negedge core_clk) rst_n = 1'b1;
            @(posedge core_clk); #1;
            chk(nm("post_rst_rdy"), rdy, 1);
            chk(nm("post_rst_vld"), dvld, 0);
            chk(nm("post_rst_busy"), busy, 0);
            d1 = rand_din();
            txn(d1, 9, 1'b1, m_sq(d1, 1'b1), m_rem(d1));

            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_cnt < 5; i++) @(posedge core_clk);
        if (done_cnt < 5) chk("all_instances_done", done_cnt, 5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
